dsi_stream_unpacker: RTL

//  Inverse of the payload byte packer. Takes a dense little-endian 32-bit byte stream
//  (packets concatenated with no gaps) plus a per-packet byte-length command. Re-splits the

---
 rtl/dsi_stream_unpacker_if.sv | 27 ++
 rtl/dsi_stream_unpacker.sv | 110 +++++++++++
 2 files changed

// File: rtl/dsi_stream_unpacker_if.sv
// Handshake bundle for the stream unpacker: packed input bytes, length commands
// and packet-aligned output words.
interface dsi_stream_unpacker_if #(
    parameter int LEN_W = 16
);
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [LEN_W-1:0] len_bytes;
    logic             len_valid;
    logic             len_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_strb;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, len_bytes, len_valid, out_ready,
        input  in_ready, len_ready, out_data, out_strb, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, len_bytes, len_valid, out_ready,
        output in_ready, len_ready, out_data, out_strb, out_last, out_valid
    );
endinterface

// File: rtl/dsi_stream_unpacker.sv
// Re-splits a dense little-endian byte stream into packet-aligned words using
// per-packet byte-length commands; an 8-byte buffer absorbs lane misalignment.
module dsi_stream_unpacker #(
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dsi_stream_unpacker_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [7:0][7:0]  buf_reg, buf_next;
    logic [3:0]       buf_cnt_reg, buf_cnt_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;

    logic [2:0] n;
    logic [3:0] cons;
    logic [3:0] avail;
    logic       out_valid;
    logic       out_last;
    logic       out_fire;
    logic       in_fire;
    logic       len_fire;
    logic       in_ready;

    assign n         = (remaining_reg >= LEN_W'(4)) ? 3'd4 : remaining_reg[2:0];
    assign out_valid = (state_reg == RUN) && (buf_cnt_reg >= {1'b0, n});
    assign out_last  = out_valid && (remaining_reg <= LEN_W'(4));
    assign out_fire  = out_valid && bus.out_ready;
    assign cons      = out_fire ? {1'b0, n} : 4'd0;
    assign avail     = buf_cnt_reg - cons;
    // Space check uses the post-consumption count so a word can land in the same
    // cycle the previous one drains; this is the only input-to-output comb path.
    assign in_ready  = (avail <= 4'd4);
    assign in_fire   = bus.in_valid && in_ready;
    assign len_fire  = bus.len_valid && (state_reg == IDLE);

    assign bus.in_ready  = in_ready;
    assign bus.len_ready = (state_reg == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_strb  = out_valid ? (4'hF >> (3'd4 - n)) : 4'h0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out_lane
            assign bus.out_data[8*gi +: 8] =
                (out_valid && (3'(gi) < n)) ? buf_reg[gi] : 8'h00;
        end
    endgenerate

    // Each buffer byte takes either the byte cons positions above it, or an
    // incoming lane when it falls in the append window starting at avail.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_buf_byte
            logic [3:0] src;
            logic [3:0] lane;
            logic [7:0] byte_next;

            always_comb begin
                src       = 4'(gi) + cons;
                lane      = 4'(gi) - avail;
                byte_next = (src < 4'd8) ? buf_reg[src[2:0]] : 8'h00;
                if (in_fire && (4'(gi) >= avail) && (lane < 4'd4)) begin
                    byte_next = bus.in_data[{lane[1:0], 3'b000} +: 8];
                end
            end

            assign buf_next[gi] = byte_next;
        end
    endgenerate

    assign buf_cnt_next = avail + (in_fire ? 4'd4 : 4'd0);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (len_fire && (bus.len_bytes != '0)) begin
                    remaining_next = bus.len_bytes;
                    state_next     = RUN;
                end
            end
            RUN: begin
                if (out_fire) begin
                    remaining_next = remaining_reg - LEN_W'(n);
                    if (out_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            buf_reg       <= '0;
            buf_cnt_reg   <= 4'd0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            buf_reg       <= buf_next;
            buf_cnt_reg   <= buf_cnt_next;
            remaining_reg <= remaining_next;
        end
    end
endmodule
